// File: rtl/spi_mem_master.sv
// spi_mem_master: host command to 10-bit SPI frame master.
// Sends {op,byte} MSB first; a read-data op captures an 8-bit MISO reply.
module spi_mem_master #(
    parameter int LEAD = 1,
    parameter int TURN = 2,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int MX1 = (LEAD > TURN) ? LEAD : TURN;
    localparam int MX  = (MX1 > GAP) ? MX1 : GAP;
    localparam int CW  = $clog2(MX + 1);

    localparam logic [CW-1:0] LEAD_LD = CW'(LEAD - 1);
    localparam logic [CW-1:0] TURN_LD = CW'(TURN - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 1) ? GAP - 2 : 0);
    localparam bit            NO_GAP  = (GAP == 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHOUT = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_SHIN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    logic [2:0]    state;
    logic [9:0]    word;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [2:0]    incnt;
    logic [6:0]    sh;

    logic accept;
    logic lead_end;
    logic shout_step;
    logic out_end;
    logic turn_end;
    logic shin_step;
    logic in_end;
    logic to_gap;
    logic gap_end;
    logic cnt_step;
    logic is_rd;

    // Decode the single event that happens this cycle.
    always_comb begin
        is_rd      = (word[9:8] == 2'b11);
        accept     = cmd_valid && cmd_ready;
        lead_end   = (state == S_LEAD) && (cnt == '0);
        shout_step = (state == S_SHOUT) && (bitcnt != 4'd0);
        out_end    = (state == S_SHOUT) && (bitcnt == 4'd0);
        turn_end   = (state == S_TURN) && (cnt == '0);
        shin_step  = (state == S_SHIN) && (incnt != 3'd0);
        in_end     = (state == S_SHIN) && (incnt == 3'd0);
        to_gap     = (state == S_DONE) && !NO_GAP;
        gap_end    = ((state == S_DONE) && NO_GAP) ||
                     ((state == S_GAP) && (cnt == '0));
        cnt_step   = ((state == S_LEAD) || (state == S_TURN) ||
                      (state == S_GAP)) && (cnt != '0);
    end

    // Frame sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            unique case (1'b1)
                accept:   state <= S_LEAD;
                lead_end: state <= S_SHOUT;
                out_end:  state <= is_rd ? S_TURN : S_DONE;
                turn_end: state <= S_SHIN;
                in_end:   state <= S_DONE;
                to_gap:   state <= S_GAP;
                gap_end:  state <= S_IDLE;
                default:  state <= state;
            endcase
        end
    end

    // Delay counter shared by LEAD, TURN and GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            unique case (1'b1)
                accept:            cnt <= LEAD_LD;
                out_end && is_rd:  cnt <= TURN_LD;
                to_gap:            cnt <= GAP_LD;
                cnt_step:          cnt <= cnt - 1'b1;
                default:           cnt <= cnt;
            endcase
        end
    end

    // Bit counters for the outgoing and incoming shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= 4'd0;
            incnt  <= 3'd0;
        end else begin
            if (lead_end) begin
                bitcnt <= 4'd9;
            end else if (shout_step) begin
                bitcnt <= bitcnt - 4'd1;
            end
            if (turn_end) begin
                incnt <= 3'd7;
            end else if (shin_step) begin
                incnt <= incnt - 3'd1;
            end
        end
    end

    // Frame word latch and MISO shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= 10'd0;
            sh   <= 7'd0;
        end else begin
            if (accept) begin
                word <= {cmd_op, cmd_data};
            end
            if (state == S_SHIN) begin
                sh <= {sh[5:0], MISO};
            end
        end
    end

    // Registered pin and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (1'b1)
                accept: begin
                    SS_n      <= 1'b0;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                end
                lead_end: begin
                    MOSI <= word[9];
                end
                shout_step: begin
                    MOSI <= word[bitcnt - 4'd1];
                end
                out_end: begin
                    MOSI <= 1'b0;
                    SS_n <= is_rd ? 1'b0 : 1'b1;
                end
                in_end: begin
                    SS_n      <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_data  <= {sh, MISO};
                end
                gap_end: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: directed and random frames against a
// frame-level timing model and a behavioural SPI RAM slave.
module tb_spi_mem_master;

    localparam int LEAD = 1;
    localparam int TURN = 2;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] wa = 8'd0;
    logic [7:0] ra = 8'd0;
    logic [7:0] exp_rsp = 8'd0;

    spi_mem_master #(.LEAD(LEAD), .TURN(TURN), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] o,
                        input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ss"}, SS_n, 1'b1);
        chk1({tag, "_mosi"}, MOSI, 1'b0);
        chk1({tag, "_rdy"}, cmd_ready, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_rv"}, rsp_valid, 1'b0);
        chk8({tag, "_rd"}, rsp_data, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1("idle_ss", SS_n, 1'b1);
            chk1("idle_rdy", cmd_ready, 1'b1);
            chk1("idle_rv", rsp_valid, 1'b0);
            chk8("idle_rd", rsp_data, exp_rsp);
        end
    endtask

    // Drives one command from a negedge and checks every cycle of its
    // frame. mode 0: valid dropped after accept; 1: valid held with junk
    // data; 2: valid and data toggled randomly. abort_at>0 pulls reset
    // in that cycle offset. Returns at a negedge where ready is expected.
    task automatic run_frame(input logic [1:0] op, input logic [7:0] d,
                             input int mode, input bit miso_hi,
                             input int abort_at);
        logic [9:0] w;
        logic [7:0] reply;
        bit         rd;
        int         dn;
        int         rdy_at;
        int         s0;
        logic       e_mosi;
        w      = {op, d};
        rd     = (op == 2'b11);
        reply  = mem[ra];
        dn     = LEAD + 11 + (rd ? TURN + 8 : 0);
        rdy_at = dn + GAP;
        s0     = LEAD + 10 + TURN + 1;
        chk1("acc_rdy", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        for (int k = 1; k <= rdy_at; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n     = 1'b0;
                cmd_valid = 1'b0;
                #1;
                exp_rsp = 8'h00;
                chk_reset_vals("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            e_mosi = 1'b0;
            if (k >= LEAD + 1 && k <= LEAD + 10) begin
                e_mosi = w[9 - (k - LEAD - 1)];
            end
            if (rd && k == dn) begin
                exp_rsp = reply;
            end
            chk1("ss", SS_n, (k >= dn));
            chk1("mosi", MOSI, e_mosi);
            chk1("busy", busy, (k < rdy_at));
            chk1("rdy", cmd_ready, (k >= rdy_at));
            chk1("rv", rsp_valid, (rd && k == dn));
            chk8("rdata", rsp_data, exp_rsp);
            if (rd && k >= s0 && k < s0 + 8) begin
                MISO = reply[7 - (k - s0)];
            end else begin
                MISO = miso_hi ? 1'b1 : 1'($urandom);
            end
            if (k == rdy_at) begin
                cmd_valid = 1'b0;
            end else if (mode == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_data  = 8'($urandom);
            end else if (mode == 2) begin
                cmd_valid = 1'($urandom);
                cmd_op    = 2'($urandom);
                cmd_data  = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        unique case (op)
            2'b00: wa = d;
            2'b01: mem[wa] = d;
            2'b10: ra = d;
            default: begin
            end
        endcase
    endtask

    initial begin
        if (LEAD < 1 || TURN < 1 || GAP < 1) begin
            $display("FAIL params LEAD=%0d TURN=%0d GAP=%0d", LEAD, TURN, GAP);
            $fatal(1);
        end
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        idle(2);

        run_frame(2'b00, 8'h3C, 0, 1'b0, 0);
        idle(1);

        run_frame(2'b00, 8'h05, 0, 1'b0, 0);
        run_frame(2'b01, 8'hA7, 0, 1'b0, 0);
        run_frame(2'b10, 8'h05, 0, 1'b0, 0);
        run_frame(2'b11, 8'h5E, 0, 1'b0, 0);
        chk8("loop_rsp", rsp_data, 8'hA7);
        idle(2);

        run_frame(2'b00, 8'h21, 1, 1'b0, 0);
        run_frame(2'b01, 8'h99, 1, 1'b0, 0);
        run_frame(2'b00, 8'h22, 1, 1'b0, 0);
        run_frame(2'b01, 8'h44, 1, 1'b0, 0);
        idle(1);

        run_frame(2'b10, 8'h21, 2, 1'b0, 0);
        run_frame(2'b11, 8'h00, 2, 1'b0, 0);
        chk8("toggle_rsp", rsp_data, 8'h99);

        run_frame(2'b00, 8'h10, 0, 1'b1, 0);
        run_frame(2'b01, 8'h00, 0, 1'b1, 0);
        run_frame(2'b10, 8'h10, 0, 1'b1, 0);
        run_frame(2'b11, 8'hFF, 0, 1'b1, 0);
        chk8("miso_hi_rsp", rsp_data, 8'h00);

        run_frame(2'b01, 8'h5A, 0, 1'b0, LEAD + 4);
        idle(3);
        run_frame(2'b10, 8'h22, 0, 1'b0, 0);
        run_frame(2'b11, 8'h00, 0, 1'b0, LEAD + 10 + TURN + 3);
        idle(3);

        for (int i = 0; i < 40; i++) begin
            run_frame(2'($urandom), 8'($urandom), $urandom_range(0, 2),
                      1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
